alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU, with the same 8-op encoding and an N/Z/V flag set. It adds valid/ready handshakes on input and output, a registered result, and an architectural flag register with per-op update rules. Shifts run iteratively at one bit per cycle, and RED accumulates one byte per cycle. It sits between decode/operand-fetch and writeback, where it can stall the pipeline.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/sat_add.sv | 22 ++
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encodings, FSM states and flag bit positions.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_RED    = 3'b010,
      OP_XOR    = 3'b011,
      OP_SLL    = 3'b100,
      OP_SRA    = 3'b101,
      OP_ROR    = 3'b110,
      OP_PADDSB = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RED   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit add/subtract with overflow detect and clamp to the signed range.
// Purely combinational; no handshake.
module sat_add #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         ovf,
   output logic [W-1:0] sat
);

   logic [W-1:0] bx;

   // Subtract as a + ~b + 1 so overflow uses the same sign rule as an add.
   assign bx  = sub ? ~b : b;
   assign sum = a + bx + {{(W-1){1'b0}}, sub};
   assign ovf = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
   assign sat = ovf ? (a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sum;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with flag register between operand fetch and writeback.
// Latency: 1 cycle for ADD/SUB/XOR/PADDSB, shamt cycles for shifts, 2*WIDTH/8 for RED.
// Backpressure: result and flags hold while out_ready=0; in_ready drops until the result drains.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int LANE    = 4,
   parameter int SHAMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flag
);

   localparam int NBYTES = 2 * WIDTH / 8;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam int ACC_W  = 9 + IDX_W;
   localparam int NLANE  = WIDTH / LANE;

   state_t               state_q, state_d;
   op_t                  op_in, op_q;
   logic                 accept, shift_in;
   logic [SHAMT_W-1:0]   shamt_in, cnt_q;
   logic [WIDTH-1:0]     work_q, work_shifted, result_q, red_res;
   logic [2*WIDTH-1:0]   bytes_q;
   logic [IDX_W-1:0]     idx_q;
   logic [ACC_W-1:0]     acc_q, acc_next;
   logic [2:0]           flag_q;
   logic [WIDTH-1:0]     add_sum_unused, add_sat, padd_res, lane_sum_unused;
   logic                 add_ovf;
   logic [NLANE-1:0]     lane_ovf_unused;

   assign op_in    = op_t'(op);
   assign shamt_in = b[SHAMT_W-1:0];
   assign shift_in = (op_in == OP_SLL) || (op_in == OP_SRA) || (op_in == OP_ROR);
   assign accept   = in_valid && in_ready;
   assign result   = result_q;
   assign flag     = flag_q;

   sat_add #(.W(WIDTH)) u_add (
      .a   (a),
      .b   (b),
      .sub (op_in == OP_SUB),
      .sum (add_sum_unused),
      .ovf (add_ovf),
      .sat (add_sat)
   );

   for (genvar g = 0; g < NLANE; g++) begin : g_lane
      sat_add #(.W(LANE)) u_lane (
         .a   (a[g*LANE +: LANE]),
         .b   (b[g*LANE +: LANE]),
         .sub (1'b0),
         .sum (lane_sum_unused[g*LANE +: LANE]),
         .ovf (lane_ovf_unused[g]),
         .sat (padd_res[g*LANE +: LANE])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE && out_ready) state_d = IDLE;
            if (accept) begin
               if (op_in == OP_RED)                   state_d = RED;
               else if (shift_in && shamt_in != '0)   state_d = SHIFT;
               else                                   state_d = DONE;
            end
         end
         SHIFT:   if (cnt_q == SHAMT_W'(1)) state_d = DONE;
         RED:     if (idx_q == IDX_W'(NBYTES - 1)) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
      out_valid = (state_q == DONE);
   end

   always_comb begin
      work_shifted = {work_q[WIDTH-2:0], 1'b0};
      case (op_q)
         OP_SRA:  work_shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         OP_ROR:  work_shifted = {work_q[0], work_q[WIDTH-1:1]};
         default: work_shifted = {work_q[WIDTH-2:0], 1'b0};
      endcase
   end

   // RED consumes the low byte of {b,a} each cycle, so a's bytes go first.
   assign acc_next = acc_q + {{(ACC_W-8){bytes_q[7]}}, bytes_q[7:0]};
   assign red_res  = {{(WIDTH-ACC_W){acc_next[ACC_W-1]}}, acc_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_ADD;
         cnt_q    <= '0;
         work_q   <= '0;
         bytes_q  <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         flag_q   <= '0;
      end else if (accept) begin
         op_q <= op_in;
         unique case (op_in)
            OP_ADD, OP_SUB: begin
               result_q <= add_sat;
               flag_q   <= {add_sat[WIDTH-1], add_sat == '0, add_ovf};
            end
            OP_XOR: begin
               result_q         <= a ^ b;
               flag_q[FLAG_Z]   <= (a ^ b) == '0;
            end
            OP_PADDSB: result_q <= padd_res;
            OP_RED: begin
               bytes_q <= {b, a};
               acc_q   <= '0;
               idx_q   <= '0;
            end
            default: begin
               work_q <= a;
               cnt_q  <= shamt_in;
               if (shamt_in == '0) begin
                  result_q       <= a;
                  flag_q[FLAG_Z] <= a == '0;
               end
            end
         endcase
      end else if (state_q == SHIFT) begin
         work_q <= work_shifted;
         cnt_q  <= cnt_q - SHAMT_W'(1);
         if (cnt_q == SHAMT_W'(1)) begin
            result_q       <= work_shifted;
            flag_q[FLAG_Z] <= work_shifted == '0;
         end
      end else if (state_q == RED) begin
         acc_q   <= acc_next;
         bytes_q <= bytes_q >> 8;
         idx_q   <= idx_q + IDX_W'(1);
         if (idx_q == IDX_W'(NBYTES - 1)) result_q <= red_res;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected result/flag pairs are queued at issue and
// checked when each result is handed off.
module tb_alu_seq;

   typedef struct packed {
      logic [15:0] r;
      logic [2:0]  f;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  op;
   logic [15:0] a, b, result;
   logic [2:0]  flag;

   int   checks = 0;
   int   errors = 0;
   int   busy;
   exp_t sb[$];

   alu_seq #(.WIDTH(16), .LANE(4), .SHAMT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag      (flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // A result transfers on the rising edge after any falling edge that sees valid && ready.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(result), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.r));
            check("flag", 32'(flag), 32'(e.f));
         end
      end
   end

   // Called just after a rising edge; returns at the falling edge where out_valid is first seen.
   task automatic issue(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic [2:0] ef, output int nbusy);
      int t;
      in_valid = 1'b1; op = o; a = av; b = bv;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
      sb.push_back('{r: er, f: ef});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      op = 3'($urandom);
      nbusy = 0;
      @(negedge clk);
      while (!out_valid && nbusy < 50) begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         nbusy++;
         @(negedge clk);
      end
      if (nbusy >= 50) check("result_timeout", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 3'b000; a = '0; b = '0;
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_flag", 32'(flag), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(3'b000, 16'h7000, 16'h2000, 16'h7FFF, 3'b001, busy);
      check("add_latency", 32'(busy), 32'd0);
      issue(3'b011, 16'h00FF, 16'h00FF, 16'h0000, 3'b011, busy);
      issue(3'b001, 16'h0005, 16'h0005, 16'h0000, 3'b010, busy);
      issue(3'b011, 16'h00FF, 16'h0F0F, 16'h0FF0, 3'b000, busy);
      issue(3'b000, 16'h8000, 16'hFFFF, 16'h8000, 3'b101, busy);
      issue(3'b101, 16'h8000, 16'h0003, 16'hF000, 3'b101, busy);
      check("sra_latency", 32'(busy), 32'd3);
      issue(3'b110, 16'h0001, 16'h0001, 16'h8000, 3'b101, busy);
      check("ror_latency", 32'(busy), 32'd1);
      issue(3'b100, 16'h1234, 16'h0000, 16'h1234, 3'b101, busy);
      check("sll0_latency", 32'(busy), 32'd0);
      issue(3'b100, 16'h8001, 16'h0001, 16'h0002, 3'b101, busy);
      issue(3'b100, 16'h8000, 16'h0001, 16'h0000, 3'b111, busy);
      issue(3'b010, 16'h7F7F, 16'h0102, 16'h0101, 3'b111, busy);
      check("red_latency", 32'(busy), 32'd4);
      issue(3'b010, 16'h8080, 16'h8080, 16'hFE00, 3'b111, busy);
      issue(3'b111, 16'h8888, 16'h8888, 16'h8888, 3'b111, busy);
      issue(3'b111, 16'h1234, 16'h1111, 16'h2345, 3'b111, busy);
      issue(3'b001, 16'h8000, 16'h0001, 16'h8000, 3'b101, busy);

      // Backpressure, then a new op accepted on the draining edge.
      out_ready = 1'b0;
      issue(3'b111, 16'h7777, 16'h1111, 16'h7777, 3'b101, busy);
      repeat (3) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_result", 32'(result), 32'h7777);
         check("bp_flag", 32'(flag), 32'b101);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      in_valid = 1'b1; op = 3'b000; a = 16'h0001; b = 16'h0001;
      sb.push_back('{r: 16'h0002, f: 3'b000});
      @(negedge clk);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;

      issue(3'b001, 16'h7FFF, 16'hFFFF, 16'h7FFF, 3'b001, busy);

      // Asynchronous reset in the middle of a long shift.
      in_valid = 1'b1; op = 3'b101; a = 16'h8000; b = 16'h000F;
      @(negedge clk);
      check("shift_accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mid_shift_busy", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_flag", 32'(flag), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(3'b000, 16'h0003, 16'hFFFB, 16'hFFFE, 3'b100, busy);
      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
